// File: rtl/ecg_r_peak_detector.sv
// ecg_r_peak_detector
// Finds R-peaks in the filtered ECG sample stream. An IDLE/SEARCH/REFRACT
// state machine tracks the maximum of each above-threshold excursion. It then
// reports that maximum together with the RR interval to the previous peak.
//
// Parameters:
//   MAX_WIDTH   - above-threshold samples in one window before a forced emit (2..255)
//   REFRACT     - valid samples ignored after each emit (1..1023)
// Ports:
//   clk         - single clock
//   reset       - synchronous, active-high
//   sample_valid- sample_in carries a new sample this cycle
//   sample_in   - signed 16-bit filtered ECG sample
//   threshold   - signed 16-bit detection threshold, applied per valid sample
//   peak_valid  - one-cycle pulse, a beat was detected
//   peak_amp    - maximum sample of the last beat (held between emits)
//   rr_interval - index distance to the previous peak, modulo 2^16
//   rr_valid    - high with peak_valid when a previous peak exists
//   beat_count  - peaks since reset, wrapping
module ecg_r_peak_detector #(
    parameter int MAX_WIDTH = 64,
    parameter int REFRACT   = 72
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic signed [15:0] sample_in,
    input  logic signed [15:0] threshold,
    output logic               peak_valid,
    output logic signed [15:0] peak_amp,
    output logic        [15:0] rr_interval,
    output logic               rr_valid,
    output logic        [15:0] beat_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WIDTH_C = 8'(MAX_WIDTH);
    localparam logic [9:0] REFRACT_C   = 10'(REFRACT);

    state_t             state_r, state_nxt_s;
    logic        [15:0] idx_r, idx_nxt_s;
    logic        [7:0]  width_r, width_nxt_s, width_inc_s;
    logic        [9:0]  ref_cnt_r, ref_cnt_nxt_s, ref_inc_s;
    logic signed [15:0] max_r, max_nxt_s;
    logic        [15:0] max_idx_r, max_idx_nxt_s;
    logic        [15:0] last_idx_r, last_idx_nxt_s;
    logic               have_last_r, have_last_nxt_s;
    logic               above_s, emit_s;
    logic               peak_valid_nxt_s, rr_valid_nxt_s;
    logic signed [15:0] peak_amp_nxt_s;
    logic        [15:0] rr_interval_nxt_s, beat_count_nxt_s;

    // Next-state and output computation for the detector state machine.
    always_comb begin
        state_nxt_s       = state_r;
        idx_nxt_s         = idx_r;
        width_nxt_s       = width_r;
        ref_cnt_nxt_s     = ref_cnt_r;
        max_nxt_s         = max_r;
        max_idx_nxt_s     = max_idx_r;
        emit_s            = 1'b0;
        width_inc_s       = width_r + 8'd1;
        ref_inc_s         = ref_cnt_r + 10'd1;
        above_s           = (sample_in > threshold);

        if (sample_valid) begin
            idx_nxt_s = idx_r + 16'd1;
            case (state_r)
                ST_IDLE: begin
                    if (above_s) begin
                        state_nxt_s   = ST_SEARCH;
                        max_nxt_s     = sample_in;
                        max_idx_nxt_s = idx_r;
                        width_nxt_s   = 8'd1;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    if (above_s) begin
                        // Strict compare so a tie keeps the earliest index.
                        if (sample_in > max_r) begin
                            max_nxt_s     = sample_in;
                            max_idx_nxt_s = idx_r;
                        end else begin
                            max_nxt_s     = max_r;
                        end
                        width_nxt_s = width_inc_s;
                        emit_s      = (width_inc_s == MAX_WIDTH_C);
                    end else begin
                        // Falling below threshold closes the window; this
                        // sample is not a candidate.
                        emit_s = 1'b1;
                    end
                end
                ST_REFRACT: begin
                    ref_cnt_nxt_s = ref_inc_s;
                    if (ref_inc_s == REFRACT_C) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_REFRACT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            idx_nxt_s = idx_r;
        end

        peak_valid_nxt_s = emit_s;
        rr_valid_nxt_s   = emit_s & have_last_r;

        // The emit uses the candidate including the terminating sample, so a
        // forced (width) emit can report a maximum set on that same sample.
        if (emit_s) begin
            peak_amp_nxt_s    = max_nxt_s;
            rr_interval_nxt_s = max_idx_nxt_s - last_idx_r;
            last_idx_nxt_s    = max_idx_nxt_s;
            have_last_nxt_s   = 1'b1;
            beat_count_nxt_s  = beat_count + 16'd1;
            state_nxt_s       = ST_REFRACT;
            ref_cnt_nxt_s     = 10'd0;
        end else begin
            peak_amp_nxt_s    = peak_amp;
            rr_interval_nxt_s = rr_interval;
            last_idx_nxt_s    = last_idx_r;
            have_last_nxt_s   = have_last_r;
            beat_count_nxt_s  = beat_count;
        end
    end

    // State and registered outputs; reset wins over any sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 16'd0;
            width_r     <= 8'd0;
            ref_cnt_r   <= 10'd0;
            max_r       <= 16'sd0;
            max_idx_r   <= 16'd0;
            last_idx_r  <= 16'd0;
            have_last_r <= 1'b0;
            peak_valid  <= 1'b0;
            peak_amp    <= 16'sd0;
            rr_interval <= 16'd0;
            rr_valid    <= 1'b0;
            beat_count  <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            width_r     <= width_nxt_s;
            ref_cnt_r   <= ref_cnt_nxt_s;
            max_r       <= max_nxt_s;
            max_idx_r   <= max_idx_nxt_s;
            last_idx_r  <= last_idx_nxt_s;
            have_last_r <= have_last_nxt_s;
            peak_valid  <= peak_valid_nxt_s;
            peak_amp    <= peak_amp_nxt_s;
            rr_interval <= rr_interval_nxt_s;
            rr_valid    <= rr_valid_nxt_s;
            beat_count  <= beat_count_nxt_s;
        end
    end

endmodule

// File: tb/tb_ecg_r_peak_detector.sv
// Scoreboard bench for ecg_r_peak_detector: stimulus pushes hand-computed
// beat records into a queue, a negedge monitor pops one per peak_valid pulse.
module tb_ecg_r_peak_detector;

    logic               clk;
    logic               reset;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic signed [15:0] threshold;
    logic               peak_valid;
    logic signed [15:0] peak_amp;
    logic        [15:0] rr_interval;
    logic               rr_valid;
    logic        [15:0] beat_count;

    typedef struct packed {
        logic signed [15:0] amp;
        logic        [15:0] rr;
        logic               rrv;
        logic        [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;
    logic prev_pv;

    logic signed [15:0] beat_vec [16];

    ecg_r_peak_detector #(.MAX_WIDTH(64), .REFRACT(72)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .threshold    (threshold),
        .peak_valid   (peak_valid),
        .peak_amp     (peak_amp),
        .rr_interval  (rr_interval),
        .rr_valid     (rr_valid),
        .beat_count   (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int amp, input int rr, input int rrv, input int cnt);
        exp_t e;
        e.amp = 16'(amp);
        e.rr  = 16'(rr);
        e.rrv = 1'(rrv);
        e.cnt = 16'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic signed [15:0] v);
        sample_valid = 1'b1;
        sample_in    = v;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_const(input logic signed [15:0] v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic send_beat(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(beat_vec[i]);
        end
    endtask

    // Monitor: compare each peak against the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (peak_valid) begin
            chk("pv_single_cycle", 32'(prev_pv), 32'd0);
            chk("peak_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("peak_amp", 32'(peak_amp), 32'(e.amp));
                chk("rr_interval", 32'(rr_interval), 32'(e.rr));
                chk("rr_valid", 32'(rr_valid), 32'(e.rrv));
                chk("beat_count", 32'(beat_count), 32'(e.cnt));
            end
        end else if (rr_valid) begin
            chk("rr_valid_outside_emit", 32'(rr_valid), 32'd0);
        end
        prev_pv = peak_valid;
    end

    initial begin
        beat_vec = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                     16'sd0, 16'sd0, 16'sd500, 16'sd1500, 16'sd3000, 16'sd3000,
                     16'sd2000, 16'sd800};
        n_pass       = 0;
        n_total      = 0;
        prev_pv      = 1'b0;
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'sd5000;
        threshold    = 16'sd1000;

        // Reset with valid samples present: everything must stay zero.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_peak_valid", 32'(peak_valid), 32'd0);
        chk("rst_peak_amp", 32'(peak_amp), 32'd0);
        chk("rst_rr_interval", 32'(rr_interval), 32'd0);
        chk("rst_rr_valid", 32'(rr_valid), 32'd0);
        chk("rst_beat_count", 32'(beat_count), 32'd0);
        reset        = 1'b0;
        sample_valid = 1'b0;

        // Single beat: indices 0..15, max at 12, no previous peak.
        push_exp(3000, 12, 0, 1);
        send_beat(1'b0);

        // RR interval: pad to index 300 so the second max sits at 312.
        send_const(16'sd0, 284);
        push_exp(3000, 300, 1, 2);
        send_beat(1'b0);

        // Refractory: 72 ignored samples (4000 at position 40), then a beat
        // at index 388.
        for (int i = 0; i < 72; i++) send((i == 40) ? 16'sd4000 : 16'sd0);
        push_exp(4000, 76, 1, 3);
        send(16'sd4000);
        send(16'sd0);
        send_const(16'sd0, 80);

        // Timeout: run of 5000 starts at index 470, emit after the 64th.
        push_exp(5000, 82, 1, 4);
        send_const(16'sd5000, 70);
        send_const(16'sd0, 80);

        // Same beat with random gaps: starts at index 620, max at 632.
        push_exp(3000, 162, 1, 5);
        send_beat(1'b1);
        send_const(16'sd0, 80);

        // Reset in the middle of a search: candidate discarded.
        send(16'sd2000);
        send(16'sd3000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_beat_count", 32'(beat_count), 32'd0);
        chk("midrst_peak_amp", 32'(peak_amp), 32'd0);
        chk("midrst_rr_interval", 32'(rr_interval), 32'd0);

        // First beat after reset: indices restart at 0, no previous peak.
        push_exp(3000, 12, 0, 1);
        send_beat(1'b0);
        send_const(16'sd0, 5);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("hold_peak_amp", 32'(peak_amp), 32'd3000);
        chk("hold_beat_count", 32'(beat_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ecg_r_peak_detector.md
# ecg_r_peak_detector

Downstream consumer of the Q15 low-pass FIR stage. It takes the filtered ECG sample stream and finds R-peaks with a threshold, track-maximum and refractory state machine. For each beat it reports the peak amplitude and the RR interval in samples. Its outputs feed the heart-rate and beat-logging logic.

## Interface
- `MAX_WIDTH`, default 64: maximum number of above-threshold samples in one search window before a forced emit. Range 2..255.
- `REFRACT`, default 72: number of valid samples ignored after each emit (200 ms at 360 Hz). Range 1..1023.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `sample_valid` in 1: `sample_in` is a new sample this cycle.
- `sample_in` in 16 signed: filtered ECG sample (FIR output).
- `threshold` in 16 signed: detection threshold. Sampled on every valid sample.
- `peak_valid` out 1: one-cycle pulse; a beat was detected.
- `peak_amp` out 16 signed: maximum sample of the beat. Holds until the next emit.
- `rr_interval` out 16: sample-index distance between this peak and the previous peak, modulo 2^16.
- `rr_valid` out 1: high with `peak_valid` when a previous peak exists.
- `beat_count` out 16: number of peaks since reset, wrapping.

## Operation
- `idx` is a 16-bit wrapping counter of accepted samples.
  - A sample's index is the value of `idx` when it is accepted.
  - `idx` increments on every `sample_valid`, in every state.
- Cycles with `sample_valid` = 0 change nothing except clearing `peak_valid`/`rr_valid`.
- All comparisons are signed. "Above" means `sample_in` > `threshold` (strictly greater).
- **IDLE**
  - Valid above-threshold sample: go to SEARCH; max = sample; max_idx = index; width = 1.
  - Otherwise stay in IDLE.
- **SEARCH**, on each valid sample:
  - Above threshold:
    - If sample > max (strict; ties keep the earliest), set max = sample and max_idx = index.
    - width += 1. If width now equals `MAX_WIDTH`, emit.
  - Not above threshold: emit. The sample is not a max candidate.
- **Emit** (registered, takes effect at the same edge):
  - `peak_valid` = 1; `peak_amp` = max.
  - `rr_interval` = max_idx − last_idx (mod 2^16); `rr_valid` = have_last.
  - last_idx = max_idx; have_last = 1; `beat_count` += 1.
  - State goes to REFRACT with ref_cnt = 0.
- **REFRACT**
  - The sample that caused the emit is not counted.
  - The next `REFRACT` valid samples are ignored: ref_cnt increments on each.
  - The valid sample that brings ref_cnt to `REFRACT` also moves the state to IDLE. That sample itself is ignored.
  - The first sample evaluated in IDLE is the one after it.
- Widths:
  - width counter is 8 bits; ref_cnt is 10 bits.
  - The RR subtraction is 16-bit unsigned wrap. Intervals of 65536 samples or more alias; this is accepted.
- `threshold` may change at any time. A change applies from the next valid sample and does not abort a SEARCH in progress.
- On reset:
  - State is IDLE; `idx`, width, ref_cnt, max, max_idx, last_idx and have_last are 0.
  - All outputs are 0: `peak_valid`, `peak_amp`, `rr_interval`, `rr_valid`, `beat_count`.
  - Reset has priority over `sample_valid`.
  - Reset during SEARCH discards the candidate with no emit. Reset during REFRACT leaves no residue.

## Timing
- Latency: `peak_valid` rises on the clock edge that accepts the terminating sample and is high for exactly that one following cycle.
- `peak_valid` is never high on two consecutive cycles, because REFRACT ≥ 1.
- `peak_amp`, `rr_interval` and `beat_count` update on the same edge as `peak_valid`.
- `rr_valid` is asserted only in the emit cycle.
- Consecutive valid samples on every cycle (the FIR rate) are supported. There is no backpressure.

## Test plan
1. **Reset.** Assert `reset` for 2 cycles with `sample_valid` = 1 and `sample_in` = 5000 → all outputs are 0, and the first valid sample after release has index 0.
2. **Single beat.** `threshold` = 1000. Send 10 samples of 0, then 500, 1500, 3000, 3000, 2000, 800 → one `peak_valid` pulse in the cycle after 800 is accepted. `peak_amp` = 3000, `rr_valid` = 0, `beat_count` = 1. The first 3000 (index 12) is recorded as max_idx.
3. **RR interval.** Repeat the stimulus of test 2 so the second maximum is at index 312 → second emit has `rr_interval` = 300, `rr_valid` = 1, `beat_count` = 2.
4. **Refractory.** After an emit, send 72 valid samples including a 4000 excursion at position 40 → no emit. Then send 4000 followed by 0 → emit with `peak_amp` = 4000.
5. **Timeout.** Send constant 5000 for 70 samples (`MAX_WIDTH` = 64) → emit after the 64th sample with `peak_amp` = 5000 and max_idx at the first sample of the run. The remaining samples fall in refractory.
6. **Gaps and mid-search reset.** Random `sample_valid` gaps during test 2 → identical results. Then assert `reset` mid-SEARCH → no `peak_valid`, and the next beat reports `rr_valid` = 0.
